// File: rtl/data_mem_pkg.sv
// Shared types and sizing helpers for the wait-state data memory.
// Imported by data_mem_array and data_memory_wait.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage: synchronous lane-masked write,
// combinational read at the same index.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   lane_en,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; lanes with a clear enable keep their contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (lane_en[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_memory_wait.sv
// MEM-stage data memory with wait states and address-error reporting.
// Optional byte-lane writes: define DATA_MEM_BYTE_EN_EN.
module data_memory_wait
    import data_mem_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_write,
`ifdef DATA_MEM_BYTE_EN_EN
    input  logic [DATA_W/8-1:0] byte_en,
`endif
    output logic [DATA_W-1:0]   data_read,
    output logic                ready,
    output logic                addr_err
);

    localparam int WB    = word_bytes(DATA_W);
    localparam int OFF_W = off_bits(DATA_W);
    localparam int IDX_W = idx_bits(DEPTH);

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   SPAN  = (ADDR_W+1)'(DEPTH * WB);
    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(WB - 1);
    localparam logic [CNT_W-1:0]  CNT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   data_read_q, data_read_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
`ifdef DATA_MEM_BYTE_EN_EN
    logic [WB-1:0]       be_q, be_d;
`endif

    logic                in_idle;
    logic [ADDR_W-1:0]   acc_addr;
    logic [ADDR_W-1:0]   acc_off;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_write;
    logic [WB-1:0]       acc_be;
    logic                acc_bad;
    logic [IDX_W-1:0]    acc_idx;
    logic                fire;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    // Operands of the completing access: live inputs when it
    // completes straight out of IDLE, latched copies otherwise
    always_comb begin
        in_idle   = (state_q == IDLE);
        acc_addr  = in_idle ? address    : addr_q;
        acc_wdata = in_idle ? data_write : wdata_q;
        acc_write = in_idle ? mem_write  : wr_q;
`ifdef DATA_MEM_BYTE_EN_EN
        acc_be    = in_idle ? byte_en    : be_q;
`else
        acc_be    = '1;
`endif
        acc_off   = acc_addr - BASE;
        acc_bad   = (acc_addr < BASE)
                 || ({1'b0, acc_off} >= SPAN)
                 || ((acc_addr & AMASK) != '0);
        acc_idx   = acc_off[OFF_W +: IDX_W];
    end

    // Next-state, counter and output-register computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
`ifdef DATA_MEM_BYTE_EN_EN
        be_d        = be_q;
`endif
        data_read_d = data_read_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        fire        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = address;
                    wdata_d = data_write;
                    wr_d    = mem_write;
`ifdef DATA_MEM_BYTE_EN_EN
                    be_d    = byte_en;
`endif
                    if (WAIT_CYCLES > 0) begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end else begin
                        state_d = DONE;
                        fire    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (fire) begin
            ready_d = 1'b1;
            if (acc_bad) begin
                err_d       = 1'b1;
                data_read_d = '0;
            end else if (!acc_write) begin
                data_read_d = mem_rdata;
            end
        end
    end

    // A reset on the completing edge abandons the write
    assign mem_we = fire && acc_write && !acc_bad && rst_n;

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
`ifdef DATA_MEM_BYTE_EN_EN
            be_q        <= '0;
`endif
            data_read_q <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
`ifdef DATA_MEM_BYTE_EN_EN
            be_q        <= be_d;
`endif
            data_read_q <= data_read_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .idx     (acc_idx),
        .wdata   (acc_wdata),
        .lane_en (acc_be),
        .rdata   (mem_rdata)
    );

    assign data_read = data_read_q;
    assign ready     = ready_q;
    assign addr_err  = err_q;

endmodule
